// File: rtl/hssi_tg_rx_checker_if.sv
// hssi_tg_rx_checker_if: RX AXI-Stream beat bundle from the MAC.
// There is no tready; the sink always accepts.
interface hssi_tg_rx_checker_if #(parameter int DATA_W = 64);
    logic                tvalid;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tuser_err;
    modport master (output tvalid, tdata, tkeep, tlast, tuser_err);
    modport slave  (input  tvalid, tdata, tkeep, tlast, tuser_err);
endinterface

// File: rtl/hssi_tg_rx_checker.sv
// hssi_tg_rx_checker: checks length/incremental payload of HE-HSSI generator packets
// and keeps saturating packet, byte and active-cycle counters for throughput.
module hssi_tg_rx_checker #(
    parameter int DATA_W      = 64,
    parameter int CRC_STRIP   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    hssi_tg_rx_checker_if.slave        rx,
    input  logic [31:0]                cfg_num_pkt,
    input  logic [15:0]                cfg_pkt_len,
    input  logic                       cfg_len_type,
    input  logic                       cfg_data_pattern,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [31:0]                pkt_cnt,
    output logic [31:0]                good_pkt_cnt,
    output logic [31:0]                len_err_cnt,
    output logic [31:0]                data_err_cnt,
    output logic [31:0]                mac_err_cnt,
    output logic [63:0]                byte_cnt,
    output logic [63:0]                active_cycles
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

    logic [1:0]    state;
    logic [31:0]   num_pkt, exp_len, len_acc, len_tot, pop;
    logic          len_rand, data_rand, len_flag, data_flag;
    logic [7:0]    pos;
    logic [IW-1:0] idle_cnt;
    logic          acc, last, zero_run, final_pkt, idle_hit, data_bad, len_bad, len_any, data_any;
    logic [64:0]   byte_sum;

    function automatic logic [31:0] sat32(input logic [31:0] v, input logic inc);
        return (inc && !(&v)) ? v + 32'd1 : v;
    endfunction

    function automatic logic [63:0] sat64(input logic [63:0] v, input logic inc);
        return (inc && !(&v)) ? v + 64'd1 : v;
    endfunction

    // pos tracks (beat_index * KEEP_W) mod 256, the expected value of lane 0
    always_comb begin
        pop = '0;
        data_bad = 1'b0;
        for (int j = 0; j < KEEP_W; j++) begin
            pop = pop + 32'(rx.tkeep[j]);
            data_bad = data_bad | (rx.tkeep[j] && rx.tdata[8*j +: 8] != pos + 8'(j));
        end
    end

    assign busy      = state == S_ARMED || state == S_RUN;
    assign done      = state == S_DONE;
    assign zero_run  = state == S_ARMED && num_pkt == '0;
    assign acc       = rx.tvalid && busy && !zero_run;
    assign last      = acc && rx.tlast;
    assign final_pkt = last && pkt_cnt == num_pkt - 32'd1;
    assign idle_hit  = busy && !acc && !zero_run && idle_cnt == IW'(TIMEOUT_CYC - 1);
    assign len_tot   = len_acc + pop;
    assign len_bad   = !len_rand && (rx.tlast ? len_tot != exp_len : rx.tkeep != '1);
    assign len_any   = len_flag || len_bad;
    assign data_any  = data_flag || (!data_rand && data_bad);
    assign byte_sum  = {1'b0, byte_cnt} + 65'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            num_pkt       <= '0;
            exp_len       <= '0;
            len_rand      <= 1'b0;
            data_rand     <= 1'b0;
            pos           <= '0;
            len_acc       <= '0;
            len_flag      <= 1'b0;
            data_flag     <= 1'b0;
            idle_cnt      <= '0;
            timeout       <= 1'b0;
            pkt_cnt       <= '0;
            good_pkt_cnt  <= '0;
            len_err_cnt   <= '0;
            data_err_cnt  <= '0;
            mac_err_cnt   <= '0;
            byte_cnt      <= '0;
            active_cycles <= '0;
        end else if (!busy) begin
            if (start) begin
                state         <= S_ARMED;
                num_pkt       <= cfg_num_pkt;
                exp_len       <= 32'(cfg_pkt_len) - 32'(CRC_STRIP);
                len_rand      <= cfg_len_type;
                data_rand     <= cfg_data_pattern;
                pos           <= '0;
                len_acc       <= '0;
                len_flag      <= 1'b0;
                data_flag     <= 1'b0;
                idle_cnt      <= '0;
                timeout       <= 1'b0;
                pkt_cnt       <= '0;
                good_pkt_cnt  <= '0;
                len_err_cnt   <= '0;
                data_err_cnt  <= '0;
                mac_err_cnt   <= '0;
                byte_cnt      <= '0;
                active_cycles <= '0;
            end
        end else begin
            if (acc) begin
                pos       <= rx.tlast ? 8'd0 : pos + 8'(KEEP_W);
                len_acc   <= rx.tlast ? '0 : len_tot;
                len_flag  <= !rx.tlast && len_any;
                data_flag <= !rx.tlast && data_any;
                byte_cnt  <= byte_sum[64] ? '1 : byte_sum[63:0];
            end
            idle_cnt      <= acc ? '0 : idle_cnt + IW'(1);
            timeout       <= idle_hit;
            active_cycles <= sat64(active_cycles, state == S_RUN || acc);
            pkt_cnt       <= sat32(pkt_cnt, last);
            len_err_cnt   <= sat32(len_err_cnt, last && len_any);
            data_err_cnt  <= sat32(data_err_cnt, last && data_any);
            mac_err_cnt   <= sat32(mac_err_cnt, last && rx.tuser_err);
            good_pkt_cnt  <= sat32(good_pkt_cnt, last && !len_any && !data_any && !rx.tuser_err);
            state         <= (zero_run || final_pkt || idle_hit) ? S_DONE : acc ? S_RUN : state;
        end
    end
endmodule

// File: tb/tb_hssi_tg_rx_checker.sv
// tb_hssi_tg_rx_checker: randomized packet runs checked against a packet-level
// reference model (per-packet byte lists, counts and beat-cycle timestamps).
module tb_hssi_tg_rx_checker;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int TO = 1000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] cfg_num_pkt = '0;
    logic [15:0] cfg_pkt_len = '0;
    logic        cfg_len_type = 1'b0, cfg_data_pattern = 1'b0;
    logic        busy, done, timeout;
    logic [31:0] pkt_cnt, good_pkt_cnt, len_err_cnt, data_err_cnt, mac_err_cnt;
    logic [63:0] byte_cnt, active_cycles;
    int          cyc = 0;
    int          total = 0, bad = 0;

    bit     m_on = 0, m_fixed, m_inc;
    longint m_num, m_explen, m_pkt, m_good, m_len, m_data, m_mac, m_bytes, m_first, m_last;

    hssi_tg_rx_checker_if #(.DATA_W(DW)) rx();

    hssi_tg_rx_checker #(.DATA_W(DW), .CRC_STRIP(4), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .cfg_num_pkt(cfg_num_pkt), .cfg_pkt_len(cfg_pkt_len),
        .cfg_len_type(cfg_len_type), .cfg_data_pattern(cfg_data_pattern),
        .start(start), .busy(busy), .done(done), .timeout(timeout),
        .pkt_cnt(pkt_cnt), .good_pkt_cnt(good_pkt_cnt), .len_err_cnt(len_err_cnt),
        .data_err_cnt(data_err_cnt), .mac_err_cnt(mac_err_cnt),
        .byte_cnt(byte_cnt), .active_cycles(active_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int len, input bit rnd, input bit flip, input bit err);
        logic [7:0] d[$];
        bit derr, lerr, live;
        live = m_on && m_pkt < m_num;
        for (int i = 0; i < len; i++) d.push_back(rnd ? 8'($urandom) : 8'(i));
        if (flip) d[5] = ~d[5];
        for (int b = 0; b * KW < len; b++) begin
            rx.tvalid = 1'b1;
            rx.tlast = (b + 1) * KW >= len;
            rx.tuser_err = err && rx.tlast;
            for (int j = 0; j < KW; j++) begin
                rx.tkeep[j] = b * KW + j < len;
                rx.tdata[8*j +: 8] = rx.tkeep[j] ? d[b*KW+j] : 8'($urandom);
            end
            if (live) begin
                if (m_first < 0) m_first = cyc;
                m_last = cyc;
            end
            @(posedge clk);
            #1;
        end
        rx.tvalid = 1'b0;
        rx.tlast = 1'b0;
        rx.tuser_err = 1'b0;
        if (live) begin
            derr = 0;
            if (m_inc) foreach (d[i]) if (d[i] != 8'(i)) derr = 1;
            lerr = m_fixed && len != m_explen;
            m_pkt++;
            m_bytes += len;
            m_len += lerr;
            m_data += derr;
            m_mac += err;
            m_good += !(lerr || derr || err);
        end
    endtask

    // cfg is scrambled right after start so the run depends on the latched copy
    task automatic do_start(input int num, input int len, input bit ltype, input bit pat);
        cfg_num_pkt = num;
        cfg_pkt_len = 16'(len);
        cfg_len_type = ltype;
        cfg_data_pattern = pat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_num_pkt = $urandom;
        cfg_pkt_len = 16'($urandom);
        cfg_len_type = 1'($urandom);
        cfg_data_pattern = 1'($urandom);
        m_on = 1; m_num = num; m_fixed = !ltype; m_inc = !pat; m_explen = len - 4;
        m_pkt = 0; m_good = 0; m_len = 0; m_data = 0; m_mac = 0; m_bytes = 0;
        m_first = -1; m_last = -1;
        chk("start_busy", busy, 1);
        chk("start_pkt_clr", pkt_cnt, 0);
        chk("start_byte_clr", byte_cnt, 0);
    endtask

    task automatic check_final(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_pkt"}, pkt_cnt, m_pkt);
        chk({tag, "_good"}, good_pkt_cnt, m_good);
        chk({tag, "_len_err"}, len_err_cnt, m_len);
        chk({tag, "_data_err"}, data_err_cnt, m_data);
        chk({tag, "_mac_err"}, mac_err_cnt, m_mac);
        chk({tag, "_bytes"}, byte_cnt, m_bytes);
        chk({tag, "_active"}, active_cycles, m_last - m_first + 1);
    endtask

    task automatic run_nominal(input string tag);
        do_start(128, 132, 0, 0);
        for (int p = 0; p < 128; p++) begin
            if (p == 127) chk({tag, "_not_done_early"}, done, 0);
            send_pkt(128, 0, 0, 0);
        end
        check_final(tag);
        chk({tag, "_active_2048"}, active_cycles, 2048);
        chk({tag, "_bytes_16384"}, byte_cnt, 16384);
    endtask

    initial begin
        int n;
        rx.tvalid = 1'b0;
        rx.tdata = '0;
        rx.tkeep = '0;
        rx.tlast = 1'b0;
        rx.tuser_err = 1'b0;
        idle(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_active", active_cycles, 0);
        rst = 1'b0;
        idle(2);
        send_pkt(128, 0, 0, 0);
        chk("idle_ignore_bytes", byte_cnt, 0);

        run_nominal("nom");

        do_start(128, 132, 0, 0);
        for (int p = 0; p < 128; p++) begin
            if (p == 50) begin
                start = 1'b1;
                idle(1);
                start = 1'b0;
            end
            send_pkt(128, 0, p == 2, 0);
            idle($urandom_range(0, 2));
        end
        check_final("corrupt");

        do_start(128, 132, 0, 0);
        for (int p = 0; p < 128; p++) send_pkt(p == 9 ? 120 : 128, 0, 0, p == 19);
        check_final("len_mac");

        do_start(40, $urandom_range(64, 1500), 1, 1);
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(64, 1500), 1, 0, 0);
            idle($urandom_range(0, 3));
        end
        check_final("random");
        send_pkt(64, 0, 0, 0);
        chk("done_ignore_bytes", byte_cnt, m_bytes);

        do_start(128, 132, 0, 0);
        for (int p = 0; p < 10; p++) send_pkt(128, 0, 0, 0);
        n = 0;
        while (!done && n < TO + 100) begin
            idle(1);
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 1);
        chk("to_busy", busy, 0);
        chk("to_pkt", pkt_cnt, 10);

        do_start(0, 132, 0, 0);
        idle(1);
        chk("zero_done", done, 1);
        chk("zero_timeout", timeout, 0);
        chk("zero_pkt", pkt_cnt, 0);

        do_start(128, 132, 0, 0);
        for (int p = 0; p < 5; p++) send_pkt(128, 0, 0, 0);
        rx.tvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        rx.tvalid = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pkt", pkt_cnt, 0);
        chk("mid_rst_bytes", byte_cnt, 0);
        chk("mid_rst_active", active_cycles, 0);
        m_on = 0;
        idle(2);
        rst = 1'b0;
        idle(1);
        run_nominal("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
